// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; start, DBIT data bits LSB first,
// even parity, one stop bit of SB_TICK ticks.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err,
    output logic            rx_busy
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t          state, state_n;
    logic [3:0]      s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n, dout_n;
    logic            par, par_n, perr, perr_n, pe_n, fe_n, done_n;
    logic            rx_m, rx_s;
    assign rx_busy = (state != IDLE);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            par          <= 1'b0;
            perr         <= 1'b0;
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            par          <= par_n;
            perr         <= perr_n;
            rx_m         <= rx;
            rx_s         <= rx_m;
            rx_dout      <= dout_n;
            rx_done_tick <= done_n;
            parity_err   <= pe_n;
            frame_err    <= fe_n;
        end
    end
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        par_n   = par;
        perr_n  = perr;
        dout_n  = rx_dout;
        pe_n    = parity_err;
        fe_n    = frame_err;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                s_n   = '0;
                n_n   = '0;
                b_n   = '0;
                par_n = 1'b0;
                if (!rx_s) state_n = START;
            end
            START: if (s_tick) begin
                // mid-start-bit check rejects glitches shorter than half a bit
                if (s == 4'd7) begin
                    if (rx_s) state_n = IDLE;
                    else begin
                        s_n     = '0;
                        state_n = DATA;
                    end
                end else s_n = s + 4'd1;
            end
            DATA: if (s_tick) begin
                if (s == 4'd15) begin
                    s_n   = '0;
                    b_n   = {rx_s, b[DBIT-1:1]};
                    par_n = par ^ rx_s;
                    if (n == NW'(DBIT - 1)) state_n = PARITY;
                    else n_n = n + 1'b1;
                end else s_n = s + 4'd1;
            end
            PARITY: if (s_tick) begin
                if (s == 4'd15) begin
                    s_n     = '0;
                    perr_n  = rx_s ^ par;
                    state_n = STOP;
                end else s_n = s + 4'd1;
            end
            STOP: if (s_tick) begin
                if (s == 4'(SB_TICK - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    dout_n  = b;
                    pe_n    = perr;
                    fe_n    = ~rx_s;
                end else s_n = s + 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DBIT, 8, number of data bits per frame, LSB first.
REQ-002 Parameter: SB_TICK, 16, number of s_tick pulses in the stop bit.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 Port: s_tick  input  1  16x oversampling tick from the baud rate generator; one clk cycle wide.
REQ-006 Port: rx  input  1  asynchronous serial line; idle high.
REQ-007 Port: rx_dout  output  DBIT  last received data word; held until the next completed frame.
REQ-008 Port: rx_done_tick  output  1  one-clk pulse marking a completed frame.
REQ-009 Port: parity_err  output  1  even-parity mismatch on the last completed frame.
REQ-010 Port: frame_err  output  1  stop bit sampled low on the last completed frame.
REQ-011 Port: rx_busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame format SHALL match the team's uart_tx: start(0), DBIT data bits LSB first, one even-parity bit (XOR of data bits), stop(1) of SB_TICK ticks.
REQ-013 rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value rx_s (2 clk latency).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with a 4-bit tick counter s, a $clog2(DBIT)-bit bit counter n, a DBIT-bit shift register b and a parity accumulator.
REQ-015 IDLE: s, n, b and parity cleared; rx_s==0 SHALL move to START.
REQ-016 START: s SHALL increment on each s_tick; on the s_tick where s==7, a high rx_s SHALL return to IDLE (glitch reject); a low rx_s SHALL clear s and enter DATA.
REQ-017 DATA: on the s_tick where s==15, rx_s SHALL shift into b[DBIT-1] (b shifts right), SHALL be XORed into the parity accumulator, and s SHALL clear; when n==DBIT-1, go to PARITY; otherwise increment n.
REQ-018 PARITY: on the s_tick where s==15, the parity error flag SHALL be computed as rx_s XOR accumulator, s SHALL clear, and the FSM SHALL go to STOP.
REQ-019 STOP: on the s_tick where s==SB_TICK-1, the FSM SHALL go to IDLE and SHALL, on that same clock edge, load rx_dout<=b, parity_err<=captured flag and frame_err<=~rx_s, and pulse rx_done_tick for exactly one clk cycle.
REQ-020 Sample points SHALL be at bit centres: start is checked at tick 8 of the bit, and each subsequent bit is sampled 16 ticks later.
REQ-021 s SHALL hold its value in clk cycles without s_tick.
REQ-022 rx_dout, parity_err and frame_err SHALL change only on rx_done_tick and SHALL hold otherwise.
REQ-023 A frame with frame_err SHALL still deliver rx_dout and rx_done_tick.
REQ-024 Back-to-back frames SHALL be received with no idle gap: a low rx_s in the cycle after STOP exits SHALL start a new frame.
REQ-025 A glitch-rejected start SHALL NOT assert rx_done_tick or alter any output.

Reset
REQ-026 When rst_n==0 at a clk edge: state=IDLE; s, n, b, parity, synchronizer flops (to 1), rx_dout=0, rx_done_tick=0, parity_err=0, frame_err=0, rx_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick; after release the block SHALL wait for a fresh falling edge.

Verification
REQ-028 Bench with s_tick every 4 clk: frame 0xA5, parity 0, stop 1 -> one rx_done_tick, rx_dout=0xA5, parity_err=0, frame_err=0.
REQ-029 Frame 0x01 with parity bit 0 -> rx_dout=0x01, parity_err=1, frame_err=0.
REQ-030 Frame 0x3C, parity 0, stop bit driven 0 -> rx_dout=0x3C, frame_err=1, rx_done_tick asserted.
REQ-031 rx low for 4 ticks, then high -> FSM returns to IDLE, no rx_done_tick, outputs unchanged.
REQ-032 rst_n low for 1 clk during DATA bit 3 of 0xFF -> no rx_done_tick; the following clean frame 0x5A -> rx_dout=0x5A.
REQ-033 Loopback from uart_tx, frames 0x00, 0xFF, 0x80 back-to-back -> three rx_done_tick pulses, each with the matching rx_dout and no errors.
